// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the PC, addresses a 1-cycle-latency
// instruction memory, and presents fetched instructions to decode through a
// valid/ready output register. Handles decode stalls, branch redirects and a
// fetch enable that lets the pipeline drain without losing an address.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'hA800_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  // Next address to issue.
  logic [31:0] pc_q, pc_d;
  // Address issued at the last edge; imem_instr currently holds its data.
  logic        req_valid_q, req_valid_d;
  logic [31:0] req_pc_q, req_pc_d;
  // Output register towards decode.
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;

  logic        accept;

  assign accept   = !out_valid_q || if_ready;
  assign if_valid = out_valid_q;
  assign if_instr = out_instr_q;
  assign if_pc    = out_pc_q;

  // Memory address: redirect target first, replay of the in-flight address
  // while stalled so the memory re-produces the same word, else the next PC.
  // Reset is folded in so the address settles to RESET_PC without an edge.
  always_comb begin
    if (!rst_n) begin
      imem_addr = RESET_PC;
    end else if (redirect_valid) begin
      imem_addr = redirect_pc;
    end else if (!accept) begin
      imem_addr = req_pc_q;
    end else begin
      imem_addr = pc_q;
    end
  end

  // Next-state selection: redirect > stall > accept (fetching or draining).
  always_comb begin
    pc_d        = pc_q;
    req_valid_d = req_valid_q;
    req_pc_d    = req_pc_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;

    if (redirect_valid) begin
      // Flush the in-flight request and the held output; restart at target.
      req_pc_d    = redirect_pc;
      req_valid_d = 1'b1;
      pc_d        = redirect_pc + 32'd1;
      out_valid_d = 1'b0;
      out_instr_d = NOP_INSTR;
    end else if (accept) begin
      out_valid_d = req_valid_q;
      out_instr_d = req_valid_q ? imem_instr : NOP_INSTR;
      out_pc_d    = req_pc_q;
      if (fetch_en) begin
        req_pc_d    = pc_q;
        req_valid_d = 1'b1;
        pc_d        = pc_q + 32'd1;
      end else begin
        // Issue nothing; pc_q is kept so fetch resumes without a gap.
        req_valid_d = 1'b0;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      req_valid_q <= 1'b0;
      req_pc_q    <= RESET_PC;
      out_valid_q <= 1'b0;
      out_instr_q <= NOP_INSTR;
      out_pc_q    <= 32'd0;
    end else begin
      pc_q        <= pc_d;
      req_valid_q <= req_valid_d;
      req_pc_q    <= req_pc_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: per-cycle vector table for the fetch scenarios, an
// in-order scoreboard of delivered (pc, instr) pairs, and a hand-written
// mid-cycle reset sequence.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'hA800_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;

  logic [31:0] exp_q[$];
  logic [31:0] sb_e;

  typedef struct {
    logic        fe;
    logic        rdy;
    logic        rd;
    logic [31:0] rpc;
    logic [31:0] addr;
    logic        v;
    logic [31:0] pc;
    logic [31:0] instr;
  } vec_t;

  vec_t vecs[21];

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'hA800_0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_en      (fetch_en),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_instr      (if_instr),
    .if_pc         (if_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h2200_0005;
      32'd1:   return 32'h2440_0003;
      32'd2:   return 32'hA800_0000;
      32'd3:   return 32'hA000_FFFD;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Synchronous instruction memory, 1-cycle read latency.
  always @(posedge clk) imem_instr <= mem_f(imem_addr);

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic fill(input logic [31:0] base);
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(base + 32'(i));
  endtask

  // Scoreboard: every decode transfer must be the next address of the
  // sequential stream started by the last reset or redirect.
  always @(posedge clk) begin
    if (!rst_n) begin
      fill(32'h0);
    end else begin
      if (if_valid && if_ready) begin
        xfers++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: got pc %08h expected none", if_pc);
        end else begin
          sb_e = exp_q.pop_front();
          check32("sb_pc", if_pc, sb_e);
          check32("sb_instr", if_instr, mem_f(sb_e));
        end
      end
      if (redirect_valid) fill(redirect_pc);
    end
  end

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      fetch_en       = vecs[i].fe;
      if_ready       = vecs[i].rdy;
      redirect_valid = vecs[i].rd;
      redirect_pc    = vecs[i].rpc;
      #1;
      check32($sformatf("r%0d_addr", i), imem_addr, vecs[i].addr);
      check32($sformatf("r%0d_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].v});
      if (vecs[i].v) begin
        check32($sformatf("r%0d_pc", i), if_pc, vecs[i].pc);
        check32($sformatf("r%0d_instr", i), if_instr, vecs[i].instr);
      end else begin
        check32($sformatf("r%0d_nop", i), if_instr, NOP);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    // fe, rdy, rd, rpc, addr, v, pc, instr
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0, 32'd0, 1'b0, 32'd0, NOP};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0, 32'd1, 1'b0, 32'd0, NOP};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h0, 32'd2, 1'b1, 32'd0, 32'h2200_0005};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0, 32'd2, 1'b1, 32'd1, 32'h2440_0003};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0, 32'd2, 1'b1, 32'd1, 32'h2440_0003};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0, 32'd2, 1'b1, 32'd1, 32'h2440_0003};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h0, 32'd3, 1'b1, 32'd1, 32'h2440_0003};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h0, 32'd4, 1'b1, 32'd2, 32'hA800_0000};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'h0, 32'd0, 1'b1, 32'd3, 32'hA000_FFFD};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'h0, 32'd1, 1'b0, 32'd0, NOP};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'd2, 1'b1, 32'd0, 32'h2200_0005};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'd2, 1'b1, 32'd1, 32'h2440_0003};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'd2, 1'b0, 32'd0, NOP};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'd2, 1'b0, 32'd0, NOP};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 32'h0, 32'd2, 1'b0, 32'd0, NOP};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 32'h0, 32'd3, 1'b0, 32'd0, NOP};
    vecs[16] = '{1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'd2, 32'hA800_0000};
    vecs[17] = '{1'b1, 1'b1, 1'b0, 32'h0, 32'd0, 1'b0, 32'd0, NOP};
    vecs[18] = '{1'b1, 1'b1, 1'b0, 32'h0, 32'd1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[19] = '{1'b1, 1'b1, 1'b0, 32'h0, 32'd2, 1'b1, 32'd0, 32'h2200_0005};
    vecs[20] = '{1'b1, 1'b1, 1'b0, 32'h0, 32'd3, 1'b1, 32'd1, 32'h2440_0003};

    rst_n          = 1'b0;
    fetch_en       = 1'b1;
    if_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Reset state.
    @(negedge clk);
    #1;
    check32("rst_valid", {31'b0, if_valid}, 32'd0);
    check32("rst_instr", if_instr, NOP);
    check32("rst_pc", if_pc, 32'd0);
    check32("rst_addr", imem_addr, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    run_rows(0, 20);

    // Mid-cycle reset pulse: state must clear without waiting for an edge.
    check32("pre_rst_valid", {31'b0, if_valid}, 32'd1);
    check32("pre_rst_pc", if_pc, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check32("async_valid", {31'b0, if_valid}, 32'd0);
    check32("async_instr", if_instr, NOP);
    check32("async_addr", imem_addr, 32'd0);
    check32("async_pc", if_pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_rows(0, 7);

    check32("xfer_count", 32'(xfers), 32'd12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the instruction memory.
- Owns the program counter (PC) and drives the word address into the instruction memory. That memory has a synchronous, 1-cycle read latency and no read enable.
- Registers the returned instruction and its PC into a valid/ready output register feeding decode.
- Supports decode back-pressure, branch redirects from execute, and a fetch enable.

Parameters:
RESET_PC, 32'h00000000, word address fetched first after reset
NOP_INSTR, 32'hA8000000, value driven on if_instr while if_valid=0 after reset or flush

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
fetch_en  input  1  1 = issue new fetches; 0 = stop issuing and let the pipeline drain
redirect_valid  input  1  taken branch/jump from execute; flush and restart at redirect_pc
redirect_pc  input  32  redirect word address
imem_addr  output  32  word address to instruction memory (combinational)
imem_instr  input  32  instruction memory read data, equal to mem[imem_addr sampled at the previous edge]
if_valid  output  1  if_instr/if_pc hold a valid fetched instruction
if_ready  input  1  decode accepts the output this cycle
if_instr  output  32  fetched instruction
if_pc  output  32  word address of if_instr

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- State registers:
  - pc_q: next address to issue.
  - req_valid_q / req_pc_q: address issued at the last edge; imem_instr currently holds mem[req_pc_q].
  - Output register: if_valid / if_instr / if_pc.
- Reset (asynchronous, immediate on rst_n=0):
  - pc_q=RESET_PC, req_valid_q=0, req_pc_q=RESET_PC.
  - if_valid=0, if_instr=NOP_INSTR, if_pc=0.
  - imem_addr=RESET_PC.
- PC arithmetic: 32-bit word index, increment by 1, wraps modulo 2^32 (32'hFFFFFFFF -> 0). No byte addressing.
- accept = !if_valid || if_ready.
- Priority, evaluated each cycle:
  1. Redirect (redirect_valid=1, overrides stall and fetch_en):
     - imem_addr=redirect_pc.
     - At the edge: req_pc_q<=redirect_pc, req_valid_q<=1, pc_q<=redirect_pc+1.
     - if_valid<=0, if_instr<=NOP_INSTR.
     - An in-flight request and a held output are discarded. Exactly one bubble cycle results.
  2. Stall (!accept):
     - imem_addr=req_pc_q, a replay so memory re-produces the same instruction next cycle.
     - pc_q, req_* and the output register are all held. No instruction is lost or duplicated.
  3. Accept with fetch_en=1:
     - imem_addr=pc_q.
     - At the edge: {if_valid,if_instr,if_pc}<={req_valid_q,imem_instr,req_pc_q}, req_pc_q<=pc_q, req_valid_q<=1, pc_q<=pc_q+1.
  4. Accept with fetch_en=0:
     - imem_addr=pc_q.
     - At the edge: output register loads as in case 3, req_valid_q<=0, pc_q held.
     - On re-enable, fetch resumes at pc_q with no skipped address.
- When the output register loads with req_valid_q=0: if_valid<=0 and if_instr<=NOP_INSTR.
- Latency:
  - Address presented in cycle N appears on if_instr after the edge ending cycle N+1.
  - From rst_n deassertion (fetch_en=1, if_ready=1): if_valid=1 after the 2nd rising edge.
  - Throughput: 1 instruction/cycle when if_ready=1.
- Decode handshake:
  - A transfer occurs on an edge where if_valid=1 and if_ready=1.
  - if_instr and if_pc are stable while if_valid=1 and if_ready=0.
- Simultaneous redirect and if_ready=1 with if_valid=1: the current output is transferred to decode at that edge, and the new if_valid is 0 (flush).
- Reset asserted mid-operation: all state returns to reset values immediately, and the outstanding request is dropped.

Test Plan:
Memory image for all scenarios: mem[0]=22000005, mem[1]=24400003, mem[2]=A8000000, mem[3]=A000FFFD, rest 0.
1. Release rst_n with fetch_en=1, if_ready=1 -> imem_addr 0,1,2,3,... per cycle. if_valid=1 after the 2nd edge, with (if_pc,if_instr) = (0,22000005), (1,24400003), (2,A8000000), (3,A000FFFD) on consecutive cycles.
2. Hold if_ready=0 for 3 cycles while if_pc=1 -> if_instr stays 24400003/1 and imem_addr stays 2. After release, pc2 then pc3 on back-to-back cycles, with no gap or duplicate.
3. redirect_valid=1, redirect_pc=0 while if_ready=0 and if_pc=3 -> imem_addr=0 that cycle, if_valid=0 next cycle, then (0,22000005) one cycle later.
4. Drop fetch_en for 4 cycles after pc1 is issued -> pc0 and pc1 are delivered, then if_valid=0. On re-enable, imem_addr=2 and pc2 is delivered next.
5. Redirect to 32'hFFFFFFFF -> the following issued address is 0, and if_pc sequence is FFFFFFFF, 0, 1.
6. Pulse rst_n low between clock edges mid-stream -> if_valid=0, if_instr=A8000000 and imem_addr=RESET_PC immediately, without waiting for an edge. Restart matches scenario 1.
